decode_stage: RTL and testbench

Parametrised ID stage for the pipelined core. It owns the IF/ID pipeline register, the register file (write-through, synchronous reset), branch/jump resolution in ID with internal forwarding, and a load-use/branch-operand hazard interlock. It sits between fetch and the ID/EX register. It drives the PC-select, stall and decoded-operand signals consumed by fetch and EX.

---
 rtl/decode_stage.sv | 170 +++++++++++++++++
 tb/tb_decode_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// ID stage: IF/ID register, write-through register file, branch/jump resolution with forwarding.
// Define DECODE_HAZARD_EN to build the load-use / branch-operand interlock; otherwise stall is tied low.
module decode_stage #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 10,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    input  logic [PC_W-1:0]   if_pc1,
    input  logic              ex_we,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_reg,
    input  logic              mem_we,
    input  logic              mem_memread,
    input  logic [REG_AW-1:0] mem_reg,
    input  logic [DATA_W-1:0] mem_alu_res,
    input  logic              wb_we,
    input  logic              wb_jal,
    input  logic [REG_AW-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              pc_src,
    output logic [PC_W-1:0]   pc_target,
    output logic              id_valid,
    output logic [REG_AW-1:0] rs,
    output logic [REG_AW-1:0] rt,
    output logic [REG_AW-1:0] dest,
    output logic [4:0]        shamt,
    output logic [11:0]       ctrl,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [DATA_W-1:0] ext_imm
);
    localparam int NREGS = 2 ** REG_AW;

    logic              ifid_valid;
    logic [31:0]       ifid_instr;
    logic [PC_W-1:0]   ifid_pc1;
    logic [DATA_W-1:0] regs [NREGS];
    logic [REG_AW-1:0] wb_addr;
    logic [REG_AW-1:0] rd;
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [15:0]       imm16;
    logic              is_rtype, is_jr, is_beq, is_bne, is_lw, is_sw, is_j, is_jal;
    logic [11:0]       ctrl_raw;
    logic [DATA_W-1:0] fwd_rs, fwd_rt;
    logic              eq;

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
            ifid_pc1   <= '0;
        end else if (stall) begin
            ifid_valid <= ifid_valid;
        end else if (pc_src) begin
            ifid_valid <= 1'b0;
        end else begin
            ifid_valid <= if_valid;
            ifid_instr <= if_instr;
            ifid_pc1   <= if_pc1;
        end
    end

    assign wb_addr = wb_jal ? {REG_AW{1'b1}} : wb_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_we && wb_addr != '0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    assign opcode = ifid_instr[31:26];
    assign funct  = ifid_instr[5:0];
    assign imm16  = ifid_instr[15:0];
    assign rs     = REG_AW'(ifid_instr[25:21]);
    assign rt     = REG_AW'(ifid_instr[20:16]);
    assign rd     = REG_AW'(ifid_instr[15:11]);
    assign shamt  = ifid_instr[10:6];
    assign ext_imm = {{(DATA_W-16){imm16[15]}}, imm16};

    // Reads of the register being written this cycle see the new value.
    always_comb begin
        read_data1 = regs[rs];
        read_data2 = regs[rt];
        if (wb_we && wb_addr == rs) read_data1 = wb_data;
        if (wb_we && wb_addr == rt) read_data2 = wb_data;
        if (rs == '0) read_data1 = '0;
        if (rt == '0) read_data2 = '0;
    end

    always_comb begin
        fwd_rs = read_data1;
        fwd_rt = read_data2;
        if (mem_we && mem_reg != '0 && mem_reg == rs && !mem_memread) fwd_rs = mem_alu_res;
        else if (wb_we && wb_addr == rs && rs != '0)                  fwd_rs = wb_data;
        if (mem_we && mem_reg != '0 && mem_reg == rt && !mem_memread) fwd_rt = mem_alu_res;
        else if (wb_we && wb_addr == rt && rt != '0)                  fwd_rt = wb_data;
    end

    assign is_rtype = (opcode == 6'h00);
    assign is_jr    = is_rtype && (funct == 6'h08);
    assign is_beq   = (opcode == 6'h04);
    assign is_bne   = (opcode == 6'h05);
    assign is_lw    = (opcode == 6'h23);
    assign is_sw    = (opcode == 6'h2B);
    assign is_j     = (opcode == 6'h02);
    assign is_jal   = (opcode == 6'h03);
    assign eq       = (fwd_rs == fwd_rt);

    // {RegDst,Branch,MemRead,MemtoReg,MemWrite,RegWrite,ALUSrc,jal,ALUOp[3:0]}
    always_comb begin
        ctrl_raw = 12'h000;
        case (opcode)
            6'h00:   ctrl_raw = is_jr ? 12'h000 : 12'h842;
            6'h23:   ctrl_raw = 12'h360;
            6'h2B:   ctrl_raw = 12'h0A0;
            6'h04,
            6'h05:   ctrl_raw = 12'h401;
            6'h03:   ctrl_raw = 12'h050;
            6'h08:   ctrl_raw = 12'h060;
            6'h0A:   ctrl_raw = 12'h065;
            6'h0C:   ctrl_raw = 12'h063;
            6'h0D:   ctrl_raw = 12'h064;
            6'h0F:   ctrl_raw = 12'h066;
            default: ctrl_raw = 12'h000;
        endcase
    end

    assign dest = ctrl_raw[11] ? rd : rt;

`ifdef DECODE_HAZARD_EN
    logic rt_src, cmp_rs, cmp_rt, load_use, br_ex, br_mem;

    always_comb begin
        rt_src   = is_rtype || is_beq || is_bne || is_sw;
        cmp_rs   = is_beq || is_bne || is_jr;
        cmp_rt   = is_beq || is_bne;
        load_use = ex_memread && ex_reg != '0 &&
                   (ex_reg == rs || (rt_src && ex_reg == rt));
        br_ex    = ex_we && ex_reg != '0 &&
                   ((cmp_rs && ex_reg == rs) || (cmp_rt && ex_reg == rt));
        br_mem   = mem_memread && mem_reg != '0 &&
                   ((cmp_rs && mem_reg == rs) || (cmp_rt && mem_reg == rt));
    end

    assign stall = ifid_valid && (load_use || br_ex || br_mem);
`else
    logic unused_ex;
    assign unused_ex = ^{ex_we, ex_memread, ex_reg, is_lw};
    assign stall     = 1'b0;
`endif

    assign id_valid = ifid_valid && !stall;
    assign ctrl     = id_valid ? ctrl_raw : 12'h000;
    assign pc_src   = id_valid &&
                      ((is_beq && eq) || (is_bne && !eq) || is_j || is_jal || is_jr);

    always_comb begin
        pc_target = ifid_pc1 + imm16[PC_W-1:0];
        if (is_j || is_jal) pc_target = ifid_instr[PC_W-1:0];
        else if (is_jr)     pc_target = fwd_rs[PC_W-1:0];
    end
endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage; expectations adapt to whether DECODE_HAZARD_EN is defined.
module tb_decode_stage;
    localparam int DATA_W = 32;
    localparam int PC_W   = 10;
    localparam int REG_AW = 5;
`ifdef DECODE_HAZARD_EN
    localparam logic HZ = 1'b1;
`else
    localparam logic HZ = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              if_valid;
    logic [31:0]       if_instr;
    logic [PC_W-1:0]   if_pc1;
    logic              ex_we, ex_memread;
    logic [REG_AW-1:0] ex_reg;
    logic              mem_we, mem_memread;
    logic [REG_AW-1:0] mem_reg;
    logic [DATA_W-1:0] mem_alu_res;
    logic              wb_we, wb_jal;
    logic [REG_AW-1:0] wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic              stall, pc_src, id_valid;
    logic [PC_W-1:0]   pc_target;
    logic [REG_AW-1:0] rs, rt, dest;
    logic [4:0]        shamt;
    logic [11:0]       ctrl;
    logic [DATA_W-1:0] read_data1, read_data2, ext_imm;

    int checks = 0;
    int errors = 0;

    decode_stage #(.DATA_W(DATA_W), .PC_W(PC_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc1(if_pc1),
        .ex_we(ex_we), .ex_memread(ex_memread), .ex_reg(ex_reg),
        .mem_we(mem_we), .mem_memread(mem_memread), .mem_reg(mem_reg), .mem_alu_res(mem_alu_res),
        .wb_we(wb_we), .wb_jal(wb_jal), .wb_reg(wb_reg), .wb_data(wb_data),
        .stall(stall), .pc_src(pc_src), .pc_target(pc_target), .id_valid(id_valid),
        .rs(rs), .rt(rt), .dest(dest), .shamt(shamt), .ctrl(ctrl),
        .read_data1(read_data1), .read_data2(read_data2), .ext_imm(ext_imm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic v, input logic [31:0] instr, input logic [PC_W-1:0] pc1);
        if_valid = v;
        if_instr = instr;
        if_pc1   = pc1;
    endtask

    task automatic clear_bypass();
        ex_we = 0; ex_memread = 0; ex_reg = '0;
        mem_we = 0; mem_memread = 0; mem_reg = '0; mem_alu_res = '0;
        wb_we = 0; wb_jal = 0; wb_reg = '0; wb_data = '0;
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [5:0] fn);
        return {6'h00, s, t, d, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    initial begin
        rst = 1'b1;
        fetch(1'b0, 32'h0, '0);
        clear_bypass();

        // reset with bubbles
        tick();
        tick();
        chk("rst_id_valid", id_valid, 0);
        chk("rst_stall", stall, 0);
        chk("rst_pc_src", pc_src, 0);
        chk("rst_ctrl", ctrl, 0);

        // write-through on add r4,r5,r6
        rst = 1'b0;
        fetch(1'b1, enc_r(5'd5, 5'd6, 5'd4, 6'h20), 10'd1);
        tick();
        wb_we = 1; wb_reg = 5'd5; wb_data = 32'hDEADBEEF;
        fetch(1'b0, 32'h0, '0);
        #1;
        chk("wt_rd1", read_data1, 32'hDEADBEEF);
        chk("add_id_valid", id_valid, 1);
        chk("add_ctrl", ctrl, 12'h842);
        chk("add_dest", dest, 5'd4);
        chk("add_rt", rt, 5'd6);
        tick();
        clear_bypass();
        fetch(1'b1, enc_r(5'd0, 5'd5, 5'd4, 6'h20), 10'd2);
        tick();
        wb_we = 1; wb_reg = 5'd0; wb_data = 32'h1234;
        fetch(1'b0, 32'h0, '0);
        #1;
        chk("r0_wt_rd1", read_data1, 0);
        chk("r5_stored_rd2", read_data2, 32'hDEADBEEF);
        tick();
        clear_bypass();
        #1;
        chk("r0_after_write", read_data1, 0);

        // beq r1,r2,+3 at pc1=0x10 with r2 forwarded from MEM
        fetch(1'b1, enc_i(6'h04, 5'd1, 5'd2, 16'd3), 10'h10);
        wb_we = 1; wb_reg = 5'd1; wb_data = 32'd7;
        tick();
        clear_bypass();
        mem_we = 1; mem_reg = 5'd2; mem_alu_res = 32'd7;
        fetch(1'b1, enc_r(5'd5, 5'd6, 5'd4, 6'h20), 10'h11);
        #1;
        chk("beq_pc_src", pc_src, 1);
        chk("beq_target", pc_target, 10'h13);
        chk("beq_ctrl", ctrl, 12'h401);
        chk("beq_ext_imm", ext_imm, 32'd3);
        chk("beq_stall", stall, 0);
        mem_we = 0;
        #1;
        chk("beq_nofwd_pc_src", pc_src, 0);
        mem_we = 1; wb_we = 1; wb_reg = 5'd2; wb_data = 32'd9;
        #1;
        chk("beq_mem_over_wb", pc_src, 1);
        tick();
        clear_bypass();
        chk("beq_squash_valid", id_valid, 0);
        chk("beq_squash_ctrl", ctrl, 0);

        // bne r1,r0,-2 at pc1=1 wraps to 0x3FF
        fetch(1'b1, enc_i(6'h05, 5'd1, 5'd0, 16'hFFFE), 10'd1);
        tick();
        fetch(1'b0, 32'h0, '0);
        #1;
        chk("bne_neg_pc_src", pc_src, 1);
        chk("bne_neg_target", pc_target, 10'h3FF);
        chk("bne_neg_ext_imm", ext_imm, 32'hFFFF_FFFE);
        tick();

        // load-use: lw r3 in EX, add r4,r3,r3 in ID
        fetch(1'b1, enc_r(5'd3, 5'd3, 5'd4, 6'h20), 10'h40);
        tick();
        ex_memread = 1; ex_we = 1; ex_reg = 5'd3;
        fetch(1'b0, 32'h0, '0);
        #1;
        chk("lu_stall", stall, HZ);
        chk("lu_id_valid", id_valid, !HZ);
        chk("lu_ctrl", ctrl, HZ ? 12'h000 : 12'h842);
        chk("lu_pc_src", pc_src, 0);
        tick();
        clear_bypass();
        #1;
        chk("lu_issue_valid", id_valid, HZ);
        chk("lu_issue_stall", stall, 0);
        fetch(1'b1, enc_i(6'h23, 5'd0, 5'd9, 16'd0), 10'h41);
        tick();
        ex_memread = 1; ex_we = 1; ex_reg = 5'd9;
        fetch(1'b0, 32'h0, '0);
        #1;
        chk("lw_rt_not_src_stall", stall, 0);
        chk("lw_ctrl", ctrl, 12'h360);
        clear_bypass();
        tick();

`ifdef DECODE_HAZARD_EN
        // branch on load: lw r8 in EX, then MEM, then WB
        fetch(1'b1, enc_i(6'h05, 5'd8, 5'd0, 16'd4), 10'h20);
        tick();
        ex_memread = 1; ex_we = 1; ex_reg = 5'd8;
        fetch(1'b0, 32'h0, '0);
        #1;
        chk("bl_ex_stall", stall, 1);
        chk("bl_ex_pc_src", pc_src, 0);
        tick();
        clear_bypass();
        mem_memread = 1; mem_we = 1; mem_reg = 5'd8; mem_alu_res = 32'd0;
        #1;
        chk("bl_mem_stall", stall, 1);
        chk("bl_mem_pc_src", pc_src, 0);
        tick();
        clear_bypass();
        wb_we = 1; wb_reg = 5'd8; wb_data = 32'd5;
        #1;
        chk("bl_wb_stall", stall, 0);
        chk("bl_wb_pc_src", pc_src, 1);
        chk("bl_wb_target", pc_target, 10'h24);
        tick();
        clear_bypass();
`endif

        // jal 0x3FF then jr r31
        fetch(1'b1, {6'h03, 26'h3FF}, 10'h30);
        tick();
        fetch(1'b1, enc_r(5'd5, 5'd6, 5'd4, 6'h20), 10'h31);
        #1;
        chk("jal_pc_src", pc_src, 1);
        chk("jal_target", pc_target, 10'h3FF);
        chk("jal_ctrl", ctrl, 12'h050);
        tick();
        chk("jal_squash_valid", id_valid, 0);
        chk("jal_squash_pc_src", pc_src, 0);
        fetch(1'b1, enc_r(5'd31, 5'd0, 5'd0, 6'h08), 10'h32);
        tick();
        wb_we = 1; wb_jal = 1; wb_reg = 5'd0; wb_data = 32'h21;
        fetch(1'b0, 32'h0, '0);
        #1;
        chk("jr_wbfwd_pc_src", pc_src, 1);
        chk("jr_wbfwd_target", pc_target, 10'h21);
        chk("jr_ctrl", ctrl, 0);
        tick();
        clear_bypass();
        fetch(1'b1, enc_r(5'd31, 5'd0, 5'd0, 6'h08), 10'h33);
        tick();
        fetch(1'b0, 32'h0, '0);
        #1;
        chk("jr_rf_target", pc_target, 10'h21);
        chk("jr_rf_rd1", read_data1, 32'h21);

        // mid-stream reset
        fetch(1'b1, enc_r(5'd5, 5'd6, 5'd4, 6'h20), 10'h34);
        rst = 1;
        ex_memread = 1; ex_we = 1; ex_reg = 5'd31;
        tick();
        chk("mrst_id_valid", id_valid, 0);
        chk("mrst_stall", stall, 0);
        chk("mrst_pc_src", pc_src, 0);
        rst = 0;
        clear_bypass();
        fetch(1'b1, enc_r(5'd31, 5'd5, 5'd4, 6'h20), 10'h50);
        tick();
        fetch(1'b0, 32'h0, '0);
        #1;
        chk("mrst_r31", read_data1, 0);
        chk("mrst_r5", read_data2, 0);
        chk("mrst_issue_valid", id_valid, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
